// File: rtl/switch_input_if.sv
`default_nettype none
// ============================================================================
//  Module : switch_input_if
//  Brief  : IO-read bus between the memory/IO mux and the switch peripheral.
//  Rev    : 1.0  initial release
// ============================================================================
interface switch_input_if;
   logic        switch_cs;
   logic        io_read;
   logic [3:0]  addr_low;
   logic [15:0] rdata;

   modport master (
      output switch_cs,
      output io_read,
      output addr_low,
      input  rdata
   );

   modport slave (
      input  switch_cs,
      input  io_read,
      input  addr_low,
      output rdata
   );
endinterface
`default_nettype wire

// File: rtl/switch_input.sv
`default_nettype none
// ============================================================================
//  Module : switch_input
//  Brief  : Synchronised, debounced board switches and confirm key with a
//           sticky key flag, read over the IO bus. Define SWITCH_PRESS_CNT_EN
//           to add an 8-bit key press counter readable at offset 0x8.
//  Rev    : 1.0  initial release
// ============================================================================
module switch_input #(
   parameter int SW_W   = 16,
   parameter int DB_CNT = 100000,
   parameter int CNT_W  = 17
) (
   input  wire            clk,
   input  wire            rst_n,
   input  wire [SW_W-1:0] sw_raw,
   input  wire            key_raw,
   switch_input_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [SW_W-1:0]  r_sw_s1;
   logic [SW_W-1:0]  r_sw_s2;
   logic [SW_W-1:0]  r_sw_s2_d;
   logic [SW_W-1:0]  r_sw_db;
   logic [CNT_W-1:0] r_sw_cnt;

   logic             r_key_s1;
   logic             r_key_s2;
   logic             r_key_s2_d;
   logic             r_key_db;
   logic [CNT_W-1:0] r_key_cnt;
   logic             r_key_flag;

   logic             w_sw_idle;
   logic             w_sw_upd;
   logic             w_key_idle;
   logic             w_key_upd;
   logic             w_key_rise;
   logic             w_rd_hit;
   logic             w_stat_clr;
   logic [15:0]      w_sw_ext;
   logic [15:0]      w_rdata;

   // Counter only runs while the synchronised input is steady and differs
   // from the debounced value; any change restarts the stability window.
   assign w_sw_idle  = (r_sw_s2 == r_sw_db) || (r_sw_s2 != r_sw_s2_d);
   assign w_sw_upd   = !w_sw_idle && (r_sw_cnt == c_cnt_last);
   assign w_key_idle = (r_key_s2 == r_key_db) || (r_key_s2 != r_key_s2_d);
   assign w_key_upd  = !w_key_idle && (r_key_cnt == c_cnt_last);
   assign w_key_rise = w_key_upd && r_key_s2;

   assign w_rd_hit   = bus.switch_cs && bus.io_read;
   assign w_stat_clr = w_rd_hit && (bus.addr_low == 4'h4);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sw_s1    <= '0;
         r_sw_s2    <= '0;
         r_sw_s2_d  <= '0;
         r_sw_db    <= '0;
         r_sw_cnt   <= '0;
         r_key_s1   <= 1'b0;
         r_key_s2   <= 1'b0;
         r_key_s2_d <= 1'b0;
         r_key_db   <= 1'b0;
         r_key_cnt  <= '0;
         r_key_flag <= 1'b0;
      end else begin
         r_sw_s1    <= sw_raw;
         r_sw_s2    <= r_sw_s1;
         r_sw_s2_d  <= r_sw_s2;
         r_key_s1   <= key_raw;
         r_key_s2   <= r_key_s1;
         r_key_s2_d <= r_key_s2;

         if (w_sw_idle) begin
            r_sw_cnt <= '0;
         end else if (w_sw_upd) begin
            r_sw_db  <= r_sw_s2;
            r_sw_cnt <= '0;
         end else begin
            r_sw_cnt <= r_sw_cnt + c_cnt_one;
         end

         if (w_key_idle) begin
            r_key_cnt <= '0;
         end else if (w_key_upd) begin
            r_key_db  <= r_key_s2;
            r_key_cnt <= '0;
         end else begin
            r_key_cnt <= r_key_cnt + c_cnt_one;
         end

         // A press landing on the same edge as a status read must not be lost.
         if (w_key_rise) begin
            r_key_flag <= 1'b1;
         end else if (w_stat_clr) begin
            r_key_flag <= 1'b0;
         end
      end
   end

`ifdef SWITCH_PRESS_CNT_EN
   logic [7:0] r_press_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_press_cnt <= 8'h00;
      end else if (w_key_rise) begin
         r_press_cnt <= r_press_cnt + 8'h01;
      end
   end
`endif

   always_comb begin
      w_sw_ext             = 16'h0000;
      w_sw_ext[SW_W-1:0]   = r_sw_db;
      w_rdata              = 16'h0000;
      if (rst_n && w_rd_hit) begin
         case (bus.addr_low)
            4'h0:    w_rdata = w_sw_ext;
            4'h4:    w_rdata = {15'b0, r_key_flag};
`ifdef SWITCH_PRESS_CNT_EN
            4'h8:    w_rdata = {8'h00, r_press_cnt};
`endif
            default: w_rdata = 16'h0000;
         endcase
      end
   end

   assign bus.rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_switch_input.sv
`default_nettype none
// ============================================================================
//  Module : tb_switch_input
//  Brief  : Scoreboard bench for switch_input against a stability-window model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_switch_input;
   localparam int SW_W   = 16;
   localparam int DB_CNT = 4;
   localparam int CNT_W  = 3;
   localparam int HN     = DB_CNT + 2;

   typedef struct {
      logic [15:0] exp;
      logic [3:0]  addr;
      logic        hit;
      int          cyc;
   } exp_t;

   logic            clk     = 1'b0;
   logic            rst_n   = 1'b0;
   logic [SW_W-1:0] sw_raw  = '0;
   logic            key_raw = 1'b0;

   switch_input_if bus ();

   switch_input #(
      .SW_W   (SW_W),
      .DB_CNT (DB_CNT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw),
      .key_raw (key_raw),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference: a debounced value takes a new level once the synchronised
   // sample history shows DB_CNT+1 identical samples differing from it.
   logic [SW_W-1:0] m_sw_h [HN];
   logic            m_key_h[HN];
   logic [SW_W-1:0] m_sw_db  = '0;
   logic            m_key_db = 1'b0;
   logic            m_flag   = 1'b0;
   logic [7:0]      m_press  = 8'h00;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   function automatic logic [15:0] model_rdata();
      logic [15:0] r;
      r = 16'h0000;
      if (rst_n && bus.switch_cs && bus.io_read) begin
         case (bus.addr_low)
            4'h0:    r = 16'(m_sw_db);
            4'h4:    r = {15'b0, m_flag};
`ifdef SWITCH_PRESS_CNT_EN
            4'h8:    r = {8'h00, m_press};
`endif
            default: r = 16'h0000;
         endcase
      end
      return r;
   endfunction

   task automatic model_edge();
      logic sw_ok, key_ok, rise, clr;
      if (!rst_n) begin
         for (int i = 0; i < HN; i++) begin
            m_sw_h[i]  = '0;
            m_key_h[i] = 1'b0;
         end
         m_sw_db  = '0;
         m_key_db = 1'b0;
         m_flag   = 1'b0;
         m_press  = 8'h00;
         return;
      end
      sw_ok  = 1'b1;
      key_ok = 1'b1;
      for (int i = 2; i < HN; i++) begin
         if (m_sw_h[i] != m_sw_h[1])   sw_ok  = 1'b0;
         if (m_key_h[i] != m_key_h[1]) key_ok = 1'b0;
      end
      rise = 1'b0;
      if (sw_ok && m_sw_h[1] != m_sw_db) m_sw_db = m_sw_h[1];
      if (key_ok && m_key_h[1] != m_key_db) begin
         rise     = m_key_h[1];
         m_key_db = m_key_h[1];
      end
      clr = bus.switch_cs && bus.io_read && (bus.addr_low == 4'h4);
      if (rise) begin
         m_flag  = 1'b1;
         m_press = m_press + 8'h01;
      end else if (clr) begin
         m_flag = 1'b0;
      end
      for (int i = HN - 1; i > 0; i--) begin
         m_sw_h[i]  = m_sw_h[i-1];
         m_key_h[i] = m_key_h[i-1];
      end
      m_sw_h[0]  = sw_raw;
      m_key_h[0] = key_raw;
   endtask

   task automatic step(input logic r, input logic [SW_W-1:0] sw, input logic k,
                       input logic cs, input logic rd, input logic [3:0] a);
      exp_t e;
      @(negedge clk);
      rst_n         = r;
      sw_raw        = sw;
      key_raw       = k;
      bus.switch_cs = cs;
      bus.io_read   = rd;
      bus.addr_low  = a;
      cyc++;
      e.exp  = model_rdata();
      e.addr = a;
      e.hit  = cs && rd;
      e.cyc  = cyc;
      exp_q.push_back(e);
      model_edge();
   endtask

   // Monitor: the DUT presents rdata every cycle; compare once inputs settle.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.rdata !== e.exp) begin
            n_bad++;
            $display("FAIL rdata cyc=%0d addr=%h hit=%0b got=%h exp=%h",
                     e.cyc, e.addr, e.hit, bus.rdata, e.exp);
         end
      end
   end

   initial begin
      logic [SW_W-1:0] sw;
      logic            k;
      logic [3:0]      a;
      logic [3:0]      addr_tab[5];
      bus.switch_cs = 1'b0;
      bus.io_read   = 1'b0;
      bus.addr_low  = 4'h0;
      for (int i = 0; i < HN; i++) begin
         m_sw_h[i]  = '0;
         m_key_h[i] = 1'b0;
      end

      // Reset then A5A5 held: visible from the seventh edge after release.
      for (int i = 0; i < 3; i++)  step(1'b0, 16'hA5A5, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b1, 4'h0);

      // Return to zero, then a 3-cycle glitch that must never appear.
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 3; i++)  step(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h0);

      // Key press held, then two status reads, release, one more read.
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h4);
      step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h4);
      step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h4);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h4);
      step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h4);

      // Status polled every cycle across the debounced rising edge.
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h4);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h4);

      // All ones debounced, then decode misses must read zero.
      for (int i = 0; i < 10; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'h0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'h0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'h0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'h2);
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'hC);
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'h0);

      // Reset mid-debounce discards progress.
      step(1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 4; i++)  step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 2; i++)  step(1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 4'h0);

      // Key held through reset yields exactly one event afterwards.
      for (int i = 0; i < 2; i++)  step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h8);
      step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h4);
      step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h4);

      // 257 debounced presses: the press counter wraps to 1.
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0);
      for (int p = 0; p < 257; p++) begin
         for (int i = 0; i < 8; i++) step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
         for (int i = 0; i < 8; i++) step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0);
         if (p == 127 || p == 255) step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h8);
      end
      step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h8);
      step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h4);

      // Randomised traffic: slow switch/key changes mixed with glitches.
      addr_tab[0] = 4'h0;
      addr_tab[1] = 4'h4;
      addr_tab[2] = 4'h8;
      addr_tab[3] = 4'h2;
      addr_tab[4] = 4'h0;
      sw = 16'h0000;
      k  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) sw = 16'($urandom);
         if ($urandom_range(0, 7) == 0)  k  = ~k;
         a = addr_tab[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) a = 4'($urandom);
         step(($urandom_range(0, 299) != 0), sw, k,
              1'($urandom), ($urandom_range(0, 3) != 0), a);
      end

      step(1'b1, sw, k, 1'b0, 1'b0, 4'h0);
      repeat (3) @(negedge clk);
      #4;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
